// File: rtl/mms_pkg.sv
// mms_pkg: shared constants and FSM state type for the max/min stream receiver.
package mms_pkg;
  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
endpackage

// File: rtl/mms_stream_rx_if.sv
// mms_stream_rx_if: input beat and result handshake bundle; out_index exists only with MMS_STREAM_INDEX_EN.
interface mms_stream_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 5
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic in_last;
  logic select;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0] out_count;
`ifdef MMS_STREAM_INDEX_EN
  logic [CNT_W-1:0] out_index;
`endif
  modport slave (
    input in_valid, in_data, in_last, select, out_ready,
    output in_ready, out_valid, result, out_count
`ifdef MMS_STREAM_INDEX_EN
    , output out_index
`endif
  );
  modport master (
    output in_valid, in_data, in_last, select, out_ready,
    input in_ready, out_valid, result, out_count
`ifdef MMS_STREAM_INDEX_EN
    , input out_index
`endif
  );
endinterface

// File: rtl/mms_cmp.sv
// mms_cmp: strict comparator, win=1 when b beats a (larger for max, smaller for min).
module mms_cmp
  import mms_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic         win
);
  assign win = (sel == SEL_MIN) ? (b < a) : (b > a);
endmodule

// File: rtl/mms_stream_rx.sv
// mms_stream_rx: per-frame max/min of an unsigned beat stream, frames closed by in_last or MAX_LEN beats.
// Define MMS_STREAM_INDEX_EN to also report the winning beat position on out_index.
module mms_stream_rx
  import mms_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  mms_stream_rx_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, result_q, result_d, nacc;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d, ncnt;
  logic sel_q, sel_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic fire, first, close, win;
  mms_cmp #(.W(DATA_W)) u_cmp (.a(acc_q), .b(bus.in_data), .sel(sel_q), .win(win));
  assign fire = bus.in_valid & in_ready_q;
  assign first = state_q == IDLE;
  assign ncnt = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign close = bus.in_last | (ncnt == CNT_W'(MAX_LEN));
  assign nacc = (first | win) ? bus.in_data : acc_q;
`ifdef MMS_STREAM_INDEX_EN
  logic [CNT_W-1:0] idx_q, idx_d, out_index_q, out_index_d, nidx;
  assign nidx = first ? '0 : (win ? cnt_q : idx_q);
  always_comb begin
    idx_d = fire ? nidx : idx_q;
    out_index_d = (fire && close) ? nidx : out_index_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      out_index_q <= '0;
    end else begin
      idx_q <= idx_d;
      out_index_q <= out_index_d;
    end
  end
  assign bus.out_index = out_index_q;
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    out_valid_d = out_valid_q;
    result_d = result_q;
    out_count_d = out_count_q;
    if (fire) begin
      acc_d = nacc;
      sel_d = first ? bus.select : sel_q;
      cnt_d = ncnt;
      state_d = close ? HOLD : ACC;
    end
    if (fire && close) begin
      out_valid_d = 1'b1;
      result_d = nacc;
      out_count_d = ncnt;
    end
    if (state_q == HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
    // registered so in_ready stays low through reset and rises a cycle after the result is taken
    in_ready_d = state_d != HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      sel_q <= 1'b0;
      cnt_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      out_count_q <= out_count_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  assign bus.out_count = out_count_q;
endmodule
